// File: rtl/addr_stepper.sv
// addr_stepper: button-conditioned address sequencer for the lab1 display path.
// Three buttons (pause, speed-up, speed-down) are synchronised, debounced and
// edge-detected. An 8-bit address then advances once per step period, and the
// speed level selects that period.

// Per-button conditioning: 2-FF synchronizer, debouncer, rising-edge pulse.
module addr_stepper_btn #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);

   localparam int unsigned DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic            sync_a;
   logic            sync_b;
   logic            level;
   logic            level_d;
   logic [DB_W-1:0] db_cnt;

   // Two-stage synchronizer for the asynchronous button input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after it has been stable for DB_CYCLES cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (sync_b == level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         level  <= sync_b;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // One-cycle pulse on the rising edge of the debounced level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// Top level: pause/speed control and the step timer.
module addr_stepper #(
   parameter int unsigned DB_CYCLES   = 1_000_000,
   parameter int unsigned BASE_PERIOD = 100_000_000,
   parameter int unsigned SPD_MAX     = 7,
   parameter int unsigned SPD_RESET   = 2,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_p,
   input  logic              btn_spdup,
   input  logic              btn_spddn,
   output logic [ADDR_W-1:0] addr,
   output logic              step,
   output logic              paused,
   output logic [2:0]        speed
);

   localparam int unsigned CNT_W    = $clog2(BASE_PERIOD);
   localparam logic [31:0] BASE     = 32'(BASE_PERIOD);
   localparam logic [2:0]  SPD_TOP  = 3'(SPD_MAX);
   localparam logic [2:0]  SPD_INIT = 3'(SPD_RESET);

   typedef enum logic {
      S_RUN   = 1'b0,
      S_PAUSE = 1'b1
   } run_state_t;

   run_state_t        state;
   run_state_t        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  last_c;
   logic [2:0]        speed_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              step_nxt;
   logic              terminal_c;
   logic              press_p;
   logic              press_up;
   logic              press_dn;

   addr_stepper_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_p (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_p),
      .press (press_p)
   );

   addr_stepper_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_up (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_spdup),
      .press (press_up)
   );

   addr_stepper_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_dn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_spddn),
      .press (press_dn)
   );

   // Next-state logic: tick counter, address step, speed level and pause toggle
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      speed_nxt  = speed;
      addr_nxt   = addr;
      step_nxt   = 1'b0;
      last_c     = CNT_W'((BASE >> speed) - 32'd1);
      terminal_c = (state == S_RUN) && (cnt == last_c);

      // Counter runs only while not paused; the terminal count steps the address
      if (state == S_RUN) begin
         if (terminal_c) begin
            cnt_nxt  = '0;
            step_nxt = 1'b1;
            addr_nxt = addr + ADDR_W'(1);
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end

      // Saturating speed change; a real change restarts the period
      if (press_up && !press_dn && (speed < SPD_TOP)) begin
         speed_nxt = speed + 3'd1;
         cnt_nxt   = '0;
      end else if (press_dn && !press_up && (speed != 3'd0)) begin
         speed_nxt = speed - 3'd1;
         cnt_nxt   = '0;
      end

      if (press_p) begin
         state_nxt = (state == S_RUN) ? S_PAUSE : S_RUN;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_RUN;
         cnt   <= '0;
         speed <= SPD_INIT;
         addr  <= '0;
         step  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         speed <= speed_nxt;
         addr  <= addr_nxt;
         step  <= step_nxt;
      end
   end

   assign paused = (state == S_PAUSE);

endmodule

// File: tb/tb_addr_stepper.sv
// Bench for addr_stepper: a cycle model predicts every step (cycle, addr) into
// a scoreboard queue; a negedge monitor pops and compares as steps appear.
module tb_addr_stepper;

   localparam int DB   = 4;
   localparam int BASE = 1024;
   localparam int SMAX = 7;
   localparam int SRST = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_p = 1'b0;
   logic       btn_spdup = 1'b0;
   logic       btn_spddn = 1'b0;
   logic [7:0] addr;
   logic       step;
   logic       paused;
   logic [2:0] speed;

   always #5 clk = ~clk;

   addr_stepper #(
      .DB_CYCLES   (DB),
      .BASE_PERIOD (BASE),
      .SPD_MAX     (SMAX),
      .SPD_RESET   (SRST),
      .ADDR_W      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_p     (btn_p),
      .btn_spdup (btn_spdup),
      .btn_spddn (btn_spddn),
      .addr      (addr),
      .step      (step),
      .paused    (paused),
      .speed     (speed)
   );

   typedef struct {
      int e_cyc;
      int e_addr;
   } sb_t;

   typedef struct {
      int         e_cyc;
      logic [2:0] m;
   } ev_t;

   sb_t  sb[$];
   ev_t  evq[$];
   int   zero_cyc[$];
   int   zero_idx[$];

   int   cyc = 0;
   int   m_cnt = 0;
   int   m_speed = SRST;
   int   m_addr = 0;
   logic m_paused = 1'b0;
   logic m_up, m_dn, m_pp, m_term;
   int   m_per;

   int   n_tests = 0;
   int   n_fail = 0;
   int   last_step_cyc = 0;
   int   prev_step_cyc = 0;
   int   last_step_addr = 0;
   int   step_count = 0;

   int   k, evt, chg_evt, pa, sc, z0;
   sb_t  got;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Cycle model of the step timer, driven by bench-predicted press edges
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc = 0; m_cnt = 0; m_speed = SRST; m_addr = 0; m_paused = 1'b0;
         sb.delete(); evq.delete(); zero_cyc.delete(); zero_idx.delete();
         step_count = 0; last_step_cyc = 0; prev_step_cyc = 0; last_step_addr = 0;
      end else begin
         cyc = cyc + 1;
         m_up = 1'b0; m_dn = 1'b0; m_pp = 1'b0;
         for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].e_cyc == cyc) begin
               m_pp = m_pp | evq[i].m[2];
               m_up = m_up | evq[i].m[1];
               m_dn = m_dn | evq[i].m[0];
               evq.delete(i);
            end
         end
         m_per  = BASE >> m_speed;
         m_term = !m_paused && (m_cnt == m_per - 1);
         if (m_term) begin
            m_addr = (m_addr + 1) % 256;
            sb.push_back('{e_cyc: cyc, e_addr: m_addr});
         end
         if (!m_paused) m_cnt = m_term ? 0 : m_cnt + 1;
         if (m_up && !m_dn && m_speed < SMAX) begin
            m_speed = m_speed + 1; m_cnt = 0;
         end else if (m_dn && !m_up && m_speed > 0) begin
            m_speed = m_speed - 1; m_cnt = 0;
         end
         if (m_pp) m_paused = !m_paused;
      end
   end

   // Monitor: pop the scoreboard on each step, compare outputs with the model
   always @(negedge clk) begin
      if (!rst) begin
         if (step) begin
            step_count++;
            check("step_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               got = sb.pop_front();
               check("step_cyc", cyc, got.e_cyc);
               check("step_addr", addr, got.e_addr);
            end
            prev_step_cyc  = last_step_cyc;
            last_step_cyc  = cyc;
            last_step_addr = addr;
            if (addr == 8'd0) begin
               zero_cyc.push_back(cyc);
               zero_idx.push_back(step_count);
            end
         end
         check("addr", addr, m_addr);
         check("speed", speed, m_speed);
         check("paused", paused, m_paused);
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Hold a button mask {p,up,dn} for 10 cycles, then release and let it settle
   task automatic press(input logic [2:0] m, output int e);
      e = cyc + DB + 4;
      evq.push_back('{e_cyc: e, m: m});
      {btn_p, btn_spdup, btn_spddn} = m;
      repeat (10) @(negedge clk);
      {btn_p, btn_spdup, btn_spddn} = 3'b000;
      repeat (10) @(negedge clk);
   endtask

   task automatic free_run_check(input string tag);
      wait_cyc(800);
      check({tag, "_steps"}, step_count, 3);
      check({tag, "_first"}, prev_step_cyc, 512);
      check({tag, "_last"}, last_step_cyc, 768);
      check({tag, "_addr"}, addr, 3);
      check({tag, "_speed"}, speed, SRST);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_addr", addr, 0);
      check("rst_step", step, 0);
      check("rst_paused", paused, 0);
      check("rst_speed", speed, SRST);
      rst = 1'b0;

      // Free-run from reset
      free_run_check("free");

      // 3-cycle glitch must not register
      btn_spdup = 1'b1;
      repeat (3) @(negedge clk);
      btn_spdup = 1'b0;
      wait_cyc(820);
      check("glitch_speed", speed, 2);

      // Clean press: speed changes on the 8th edge after the first sampled high
      chg_evt = cyc + 8;
      evq.push_back('{e_cyc: chg_evt, m: 3'b010});
      btn_spdup = 1'b1;
      repeat (7) @(negedge clk);
      check("spd_edge7", speed, 2);
      @(negedge clk);
      check("spd_edge8", speed, 3);
      repeat (2) @(negedge clk);
      btn_spdup = 1'b0;
      wait_cyc(chg_evt + 2 * 128 + 4);
      check("p128_first", prev_step_cyc, chg_evt + 128);
      check("p128_second", last_step_cyc, chg_evt + 256);

      // Saturation at the top
      for (int i = 0; i < 6; i++) press(3'b010, evt);
      check("sat_top", speed, 7);
      press(3'b010, evt);
      check("sat_top_again", speed, 7);

      // Down to zero; the 7th press is the last real change
      for (int i = 0; i < 9; i++) begin
         press(3'b001, evt);
         if (i == 6) chg_evt = evt;
      end
      check("sat_bot", speed, 0);
      wait_cyc(chg_evt + 1024 + 4);
      check("p1024", last_step_cyc, chg_evt + 1024);

      // Back to speed 2, then simultaneous up+dn
      press(3'b010, evt);
      press(3'b010, evt);
      check("spd_back2", speed, 2);
      press(3'b011, evt);
      check("spd_simul", speed, 2);

      // Pause with the tick count landing on 100
      k = 0;
      while (m_cnt != 92 && k < 600) begin
         @(negedge clk);
         k++;
      end
      check("pause_sync_timeout", 32'(k < 600), 1);
      press(3'b100, evt);
      check("pause_on", paused, 1);
      pa = addr;
      sc = step_count;
      repeat (300) @(negedge clk);
      check("pause_addr_hold", addr, pa);
      check("pause_no_step", step_count, sc);
      press(3'b100, evt);
      check("pause_off", paused, 0);
      wait_cyc(evt + 160);
      check("resume_step_cyc", last_step_cyc, evt + 156);
      check("resume_step_addr", last_step_addr, (pa + 1) % 256);

      // Wrap at speed 7
      for (int i = 0; i < 5; i++) press(3'b010, evt);
      check("wrap_speed", speed, 7);
      z0 = zero_cyc.size();
      k = 0;
      while (zero_cyc.size() < z0 + 2 && k < 4300) begin
         @(negedge clk);
         k++;
      end
      check("wrap_timeout", 32'(k < 4300), 1);
      if (zero_cyc.size() >= z0 + 2) begin
         check("wrap_steps", zero_idx[z0+1] - zero_idx[z0], 256);
         check("wrap_cycles", zero_cyc[z0+1] - zero_cyc[z0], 256 * 8);
      end

      // Pause press landing on a terminal count: the step to 0x5A still happens
      k = 0;
      while (!(m_addr == 8'h59 && m_cnt == 0) && k < 2200) begin
         @(negedge clk);
         k++;
      end
      check("a59_timeout", 32'(k < 2200), 1);
      press(3'b100, evt);
      check("pt_step_cyc", last_step_cyc, evt);
      check("pt_addr", addr, 8'h5A);
      check("pt_paused", paused, 1);

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      check("arst_addr", addr, 0);
      check("arst_step", step, 0);
      check("arst_paused", paused, 0);
      check("arst_speed", speed, SRST);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      free_run_check("rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish, cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
